// File: rtl/vend_pkg.sv
// Shared vending types: coin codes, coin values in nickels and the dispenser state encoding.
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'b00,
      COIN_NICKEL  = 2'b01,
      COIN_DIME    = 2'b10,
      COIN_QUARTER = 2'b11
   } coin_t;

   localparam int unsigned NickelVal  = 1;
   localparam int unsigned DimeVal    = 2;
   localparam int unsigned QuarterVal = 5;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StDispense,
      StDone,
      StFault
   } disp_state_t;

   // Value of a coin code in nickels; COIN_NONE is worth nothing.
   function automatic int unsigned coin_value(coin_t c);
      case (c)
         COIN_QUARTER: return QuarterVal;
         COIN_DIME:    return DimeVal;
         COIN_NICKEL:  return NickelVal;
         default:      return 0;
      endcase
   endfunction

endpackage

// File: rtl/coin_selector.sv
// Greedy coin pick: largest coin that fits the remaining amount and is in stock.
module coin_selector import vend_pkg::*; #(
   parameter int unsigned AMT_W = 5,
   parameter int unsigned INV_W = 6
) (
   input  logic [AMT_W-1:0] remaining_i,
   input  logic [INV_W-1:0] inv_q_i,
   input  logic [INV_W-1:0] inv_d_i,
   input  logic [INV_W-1:0] inv_n_i,
   output logic [1:0]       coin_o,
   output logic             none_usable_o
);

   // Priority pick quarter > dime > nickel; none_usable only when something is still owed.
   always_comb begin
      coin_o = COIN_NONE;
      if (remaining_i >= AMT_W'(QuarterVal) && inv_q_i != '0) begin
         coin_o = COIN_QUARTER;
      end else if (remaining_i >= AMT_W'(DimeVal) && inv_d_i != '0) begin
         coin_o = COIN_DIME;
      end else if (remaining_i >= AMT_W'(NickelVal) && inv_n_i != '0) begin
         coin_o = COIN_NICKEL;
      end
      none_usable_o = (remaining_i != '0) && (coin_o == COIN_NONE);
   end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return engine: pays out a nickel amount one coin at a time over a valid/ack handshake.
module change_dispenser import vend_pkg::*; #(
   parameter int unsigned AMT_W   = 5,
   parameter int unsigned INV_W   = 6,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [AMT_W-1:0] change_amt_i,
   input  logic             restock_i,
   input  logic [INV_W-1:0] restock_q_i,
   input  logic [INV_W-1:0] restock_d_i,
   input  logic [INV_W-1:0] restock_n_i,
   output logic             busy_o,
   output logic             coin_valid_o,
   output logic [1:0]       coin_code_o,
   input  logic             coin_ack_i,
   output logic             done_o,
   output logic             short_flag_o,
   output logic [AMT_W-1:0] short_amt_o,
   output logic             fault_o,
   output logic [INV_W-1:0] inv_q_o,
   output logic [INV_W-1:0] inv_d_o,
   output logic [INV_W-1:0] inv_n_o
);

   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

   disp_state_t      state_q, state_d;
   logic [AMT_W-1:0] remaining_q, remaining_d;
   coin_t            coin_q, coin_d;
   logic [INV_W-1:0] inv_qtr_q, inv_qtr_d;
   logic [INV_W-1:0] inv_dim_q, inv_dim_d;
   logic [INV_W-1:0] inv_nik_q, inv_nik_d;
   logic [TmoW-1:0]  tmo_q, tmo_d;
   logic             short_flag_q, short_flag_d;
   logic [AMT_W-1:0] short_amt_q, short_amt_d;

   logic [1:0]       pick;
   logic             none_usable;
   logic             tmo_hit;

   coin_selector #(
      .AMT_W(AMT_W),
      .INV_W(INV_W)
   ) u_coin_selector (
      .remaining_i  (remaining_q),
      .inv_q_i      (inv_qtr_q),
      .inv_d_i      (inv_dim_q),
      .inv_n_i      (inv_nik_q),
      .coin_o       (pick),
      .none_usable_o(none_usable)
   );

   // This cycle is the TIMEOUT-th one spent in DISPENSE.
   assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (start_i) state_d = StSelect;
         StSelect:   state_d = (pick != COIN_NONE) ? StDispense : StDone;
         StDispense: begin
            if (coin_ack_i)   state_d = StSelect;
            else if (tmo_hit) state_d = StFault;
         end
         StDone:     state_d = StIdle;
         StFault:    state_d = StFault;
         default:    state_d = StIdle;
      endcase
   end

   // Datapath next values: amount, latched coin, inventory, timeout and short result.
   always_comb begin
      remaining_d  = remaining_q;
      coin_d       = coin_q;
      inv_qtr_d    = inv_qtr_q;
      inv_dim_d    = inv_dim_q;
      inv_nik_d    = inv_nik_q;
      tmo_d        = '0;
      short_flag_d = short_flag_q;
      short_amt_d  = short_amt_q;
      case (state_q)
         StIdle: begin
            if (restock_i) begin
               inv_qtr_d = restock_q_i;
               inv_dim_d = restock_d_i;
               inv_nik_d = restock_n_i;
            end
            if (start_i) remaining_d = change_amt_i;
         end
         StSelect: begin
            coin_d       = coin_t'(pick);
            short_flag_d = none_usable;
            short_amt_d  = none_usable ? remaining_q : '0;
         end
         StDispense: begin
            if (coin_ack_i) begin
               // Picked coin never exceeds remaining, so this cannot underflow.
               remaining_d = remaining_q - AMT_W'(coin_value(coin_q));
               case (coin_q)
                  COIN_QUARTER: if (inv_qtr_q != '0) inv_qtr_d = inv_qtr_q - INV_W'(1);
                  COIN_DIME:    if (inv_dim_q != '0) inv_dim_d = inv_dim_q - INV_W'(1);
                  COIN_NICKEL:  if (inv_nik_q != '0) inv_nik_d = inv_nik_q - INV_W'(1);
                  default: ;
               endcase
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         remaining_q  <= '0;
         coin_q       <= COIN_NONE;
         inv_qtr_q    <= '0;
         inv_dim_q    <= '0;
         inv_nik_q    <= '0;
         tmo_q        <= '0;
         short_flag_q <= 1'b0;
         short_amt_q  <= '0;
      end else begin
         remaining_q  <= remaining_d;
         coin_q       <= coin_d;
         inv_qtr_q    <= inv_qtr_d;
         inv_dim_q    <= inv_dim_d;
         inv_nik_q    <= inv_nik_d;
         tmo_q        <= tmo_d;
         short_flag_q <= short_flag_d;
         short_amt_q  <= short_amt_d;
      end
   end

   // Outputs decoded from state; short result is only exposed alongside done.
   always_comb begin
      busy_o       = (state_q != StIdle) && (state_q != StFault);
      coin_valid_o = (state_q == StDispense);
      coin_code_o  = coin_valid_o ? coin_q : COIN_NONE;
      done_o       = (state_q == StDone);
      short_flag_o = done_o && short_flag_q;
      short_amt_o  = done_o ? short_amt_q : '0;
      fault_o      = (state_q == StFault);
      inv_q_o      = inv_qtr_q;
      inv_d_o      = inv_dim_q;
      inv_n_o      = inv_nik_q;
   end

endmodule
